// File: rtl/divider_counter_if.sv
// divider_counter_if: count-enable / count-value bundle for divider_counter.
// Tc is carried only when DIVIDER_COUNTER_TC_EN is defined.
interface divider_counter_if #(
    parameter int WIDTH = 32
);
    logic             En;
    logic [WIDTH-1:0] Out;
`ifdef DIVIDER_COUNTER_TC_EN
    logic             Tc;

    modport master (
        output En,
        input  Out,
        input  Tc
    );

    modport slave (
        input  En,
        output Out,
        output Tc
    );
`else
    modport master (
        output En,
        input  Out
    );

    modport slave (
        input  En,
        output Out
    );
`endif
endinterface

// File: rtl/divider_counter.sv
// divider_counter: WIDTH-bit T-flip-flop up-counter, usable as a divider tap set.
// Define DIVIDER_COUNTER_TC_EN to add the terminal-count output Tc.
module divider_counter #(
    parameter int WIDTH = 32
) (
    input  logic Clk,
    input  logic Reset,
    divider_counter_if.slave bus
);

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("divider_counter: WIDTH must be 4..32");
    end

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t;
    logic             carry;

    // Ripple AND chain: bit i toggles once every lower bit is 1.
    always_comb begin
        carry = 1'b1;
        t     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]  = carry;
            carry = carry & q[i];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q <= '0;
        end else begin
            q <= q ^ (t & {WIDTH{bus.En}});
        end
    end

    assign bus.Out = q;

`ifdef DIVIDER_COUNTER_TC_EN
    // Reset holds q at zero, so Tc is low throughout reset.
    assign bus.Tc = bus.En & (&q);
`endif

endmodule

// File: tb/tb_divider_counter.sv
// tb_divider_counter: randomized and directed checks of divider_counter
// at WIDTH=32 and WIDTH=4 against an arithmetic reference model.
module tb_divider_counter;

    logic Clk = 1'b0;
    logic rst32;
    logic rst4;

    int checks = 0;
    int fails  = 0;

    longint exp32;
    int     exp4;

    always #5 Clk = ~Clk;

    divider_counter_if #(.WIDTH(32)) b32 ();
    divider_counter_if #(.WIDTH(4))  b4 ();

    divider_counter #(.WIDTH(32)) u32 (
        .Clk   (Clk),
        .Reset (rst32),
        .bus   (b32)
    );

    divider_counter #(.WIDTH(4)) u4 (
        .Clk   (Clk),
        .Reset (rst4),
        .bus   (b4)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst32 = 1'b1;
        b32.En = 1'b0;
        exp32 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (k >= 5) b32.En = 1'b1;
            checks++;
            if (b32.Out !== 32'd0) begin
                fails++;
                $display("FAIL reset_hold: Out=%0h expected 0", b32.Out);
            end
        end
        rst32 = 1'b0;
        b32.En = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            exp32 = (exp32 + 1) & 64'hFFFF_FFFF;
            checks++;
            if (b32.Out !== exp32[31:0]) begin
                fails++;
                $display("FAIL reset_count: Out=%0h expected %0h",
                         b32.Out, exp32[31:0]);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge Clk);
        rst32 = 1'b1;
        #1 rst32 = 1'b0;
        exp32 = 0;
        b32.En = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            exp32++;
        end
        checks++;
        if (b32.Out !== 32'd5) begin
            fails++;
            $display("FAIL hold_reach5: Out=%0h expected 5", b32.Out);
        end
        b32.En = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            checks++;
            if (b32.Out !== exp32[31:0]) begin
                fails++;
                $display("FAIL hold_idle: Out=%0h expected %0h",
                         b32.Out, exp32[31:0]);
            end
        end
        b32.En = 1'b1;
        @(negedge Clk);
        exp32++;
        checks++;
        if (b32.Out !== 32'd6) begin
            fails++;
            $display("FAIL hold_resume: Out=%0h expected 6", b32.Out);
        end
    endtask

    task automatic test_async_reset();
        @(negedge Clk);
        rst32 = 1'b1;
        #1 rst32 = 1'b0;
        b32.En = 1'b1;
        for (int k = 0; k < 9; k++) @(negedge Clk);
        checks++;
        if (b32.Out !== 32'd9) begin
            fails++;
            $display("FAIL async_reach9: Out=%0h expected 9", b32.Out);
        end
        #2 rst32 = 1'b1;
        #1;
        checks++;
        if (b32.Out !== 32'd0) begin
            fails++;
            $display("FAIL async_clear: Out=%0h expected 0", b32.Out);
        end
        @(negedge Clk);
        checks++;
        if (b32.Out !== 32'd0) begin
            fails++;
            $display("FAIL reset_dominates: Out=%0h expected 0", b32.Out);
        end
        rst32 = 1'b0;
        @(negedge Clk);
        exp32 = 1;
        checks++;
        if (b32.Out !== 32'd1) begin
            fails++;
            $display("FAIL first_after_reset: Out=%0h expected 1", b32.Out);
        end
    endtask

    task automatic test_wrap4();
        int seq[$];
        @(negedge Clk);
        b4.En = 1'b1;
        rst4 = 1'b1;
        #1;
`ifdef DIVIDER_COUNTER_TC_EN
        checks++;
        if (b4.Tc !== 1'b0) begin
            fails++;
            $display("FAIL tc_in_reset: Tc=%b expected 0", b4.Tc);
        end
`endif
        rst4 = 1'b0;
        exp4 = 0;
        for (int k = 0; k < 16; k++) begin
`ifdef DIVIDER_COUNTER_TC_EN
            checks++;
            if (b4.Tc !== (exp4 == 15)) begin
                fails++;
                $display("FAIL tc_wrap4: Tc=%b expected %b at Out=%0d",
                         b4.Tc, (exp4 == 15), exp4);
            end
`endif
            @(negedge Clk);
            exp4 = (exp4 + 1) % 16;
            seq.push_back(int'(b4.Out));
        end
        checks++;
        if (seq[13] != 14 || seq[14] != 15 || seq[15] != 0) begin
            fails++;
            $display("FAIL wrap4_seq: got %0d,%0d,%0d expected 14,15,0",
                     seq[13], seq[14], seq[15]);
        end
    endtask

    task automatic test_divider();
        int     bad0;
        int     last3;
        int     minh;
        int     maxh;
        logic   p0;
        logic   p3;
        @(negedge Clk);
        rst32 = 1'b1;
        #1 rst32 = 1'b0;
        b32.En = 1'b1;
        bad0  = 0;
        last3 = 0;
        minh  = 1 << 30;
        maxh  = 0;
        p0 = b32.Out[0];
        p3 = b32.Out[3];
        for (int n = 1; n <= 1024; n++) begin
            @(negedge Clk);
            if (b32.Out[0] === p0) bad0++;
            if (b32.Out[3] !== p3) begin
                if (last3 > 0) begin
                    if (n - last3 < minh) minh = n - last3;
                    if (n - last3 > maxh) maxh = n - last3;
                end
                last3 = n;
            end
            p0 = b32.Out[0];
            p3 = b32.Out[3];
        end
        exp32 = 1024;
        checks++;
        if (b32.Out !== 32'd1024) begin
            fails++;
            $display("FAIL div_1024: Out=%0h expected %0h", b32.Out, 1024);
        end
        checks++;
        if (bad0 != 0) begin
            fails++;
            $display("FAIL div_bit0: %0d missed toggles expected 0", bad0);
        end
        checks++;
        if (minh != (1 << 3) || maxh != (1 << 3)) begin
            fails++;
            $display("FAIL div_bit3: half-period %0d..%0d expected %0d",
                     minh, maxh, (1 << 3));
        end
    endtask

    task automatic test_deposit();
        @(negedge Clk);
        b32.En = 1'b1;
        force u32.q = 32'hFFFF_FFFE;
        #1 release u32.q;
        @(negedge Clk);
        checks++;
        if (b32.Out !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL deposit_ones: Out=%0h expected ffffffff", b32.Out);
        end
`ifdef DIVIDER_COUNTER_TC_EN
        checks++;
        if (b32.Tc !== 1'b1) begin
            fails++;
            $display("FAIL deposit_tc: Tc=%b expected 1", b32.Tc);
        end
`endif
        @(negedge Clk);
        checks++;
        if (b32.Out !== 32'h0) begin
            fails++;
            $display("FAIL deposit_wrap: Out=%0h expected 0", b32.Out);
        end
        exp32 = 0;
    endtask

    task automatic test_random();
        logic e32;
        logic e4;
        @(negedge Clk);
        rst32 = 1'b1;
        rst4  = 1'b1;
        #1;
        rst32 = 1'b0;
        rst4  = 1'b0;
        exp32 = 0;
        exp4  = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                #1 rst4 = 1'b1;
                #1 rst4 = 1'b0;
                exp4 = 0;
            end
            e32 = 1'($urandom_range(0, 3) != 0);
            e4  = 1'($urandom_range(0, 3) != 0);
            b32.En = e32;
            b4.En  = e4;
            #1;
`ifdef DIVIDER_COUNTER_TC_EN
            checks++;
            if (b4.Tc !== (e4 && exp4 == 15)) begin
                fails++;
                $display("FAIL rand_tc4: Tc=%b expected %b",
                         b4.Tc, (e4 && exp4 == 15));
            end
`endif
            @(negedge Clk);
            if (e32) exp32 = (exp32 + 1) & 64'hFFFF_FFFF;
            if (e4)  exp4  = (exp4 + 1) % 16;
            checks++;
            if (b32.Out !== exp32[31:0]) begin
                fails++;
                $display("FAIL rand_out32: Out=%0h expected %0h",
                         b32.Out, exp32[31:0]);
            end
            checks++;
            if (int'(b4.Out) != exp4) begin
                fails++;
                $display("FAIL rand_out4: Out=%0d expected %0d",
                         b4.Out, exp4);
            end
        end
    endtask

    initial begin
        rst32  = 1'b1;
        rst4   = 1'b1;
        b32.En = 1'b0;
        b4.En  = 1'b0;
        test_reset();
        test_hold();
        test_async_reset();
        test_wrap4();
        test_divider();
        test_deposit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
